cram_load_packer: RTL
=====================

Name: cram_load_packer

Overview:
- Upstream write feeder for the cellular-RAM controller.
- Accepts the byte stream from the bridge/loader path and packs it into 32-bit words, high byte first.
- Buffers the packed words with their byte addresses in a small FIFO.
- Issues each word to the controller over the toggle handshake: `we_req` / `we_ack` with `wraddr[23:0]` and `din[31:0]`.

Parameters:
- DEPTH, 4: FIFO depth in words; must be a power of two, minimum 2.
- PAD, 8'hFF: byte used to fill unwritten lanes when a partial word is flushed.

Ports:
- cram_clk  in  1  single clock, shared with the RAM controller.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; loads start_addr and aborts any buffered data.
- start_addr  in  24  byte address of the first byte; bits [1:0] are ignored (word aligned).
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  input byte.
- byte_ready  out  1  byte is accepted on an edge where byte_valid && byte_ready.
- flush  in  1  one-cycle pulse; pads and commits any partial word.
- wraddr  out  24  byte address of the presented word; bits [1:0] are always 0.
- din  out  32  word data; [31:16] is written first as the high half.
- we_req  out  1  toggle request; a request is pending while we_req != we_ack.
- we_ack  in  1  toggle acknowledge from the controller.
- words_done  out  16  count of acknowledged words since the last start; wraps.
- done  out  1  high when there is no partial word, the FIFO is empty, no request is pending and no flush is waiting.

Behaviour:
- **Reset values:** we_req=0, wraddr=0, din=0, words_done=0, done=1, byte_ready=1. Internally the word address is 0, the pack count is 0 and the FIFO is empty.
- **Reset mid-transfer:** all data is dropped. we_req returns to 0, so the controller must also be reset in the same domain.
- **Packing:** a 2-bit pack count tracks byte lanes.
  - Lanes fill in order 0..3 into bits [31:24], [23:16], [15:8], [7:0].
  - On the 4th accepted byte, the word and the current word address are pushed into the FIFO on that same edge.
  - The word address then advances by 4, modulo 2^24 (0xFFFFFC wraps to 0x000000).
- **Input flow control:** byte_ready = ~fifo_full. Bytes are never dropped.
- **Flush:**
  - If the pack count is 0, flush is a no-op.
  - Otherwise the unfilled lanes are set to PAD and the word is pushed; the pack count clears and the address advances by 4.
  - If the FIFO is full, the flush is held pending and byte_ready stays low until the push happens.
  - A flush on the same edge as a 4th byte applies to the following word, which is empty, so it is a no-op.
- **Issue FSM states:** IDLE and WAIT.
  - In IDLE, when we_req == we_ack and the FIFO is non-empty: pop the head, register wraddr/din, toggle we_req, and go to WAIT.
  - In WAIT, when we_ack == we_req: increment words_done and return to IDLE.
  - wraddr and din must stay stable throughout WAIT.
- **Latency:** with the FIFO empty and IDLE, we_req toggles on the edge after the 4th byte's edge, i.e. 1 cycle after the push. At most one request is outstanding at a time.
- **Simultaneous events:** push and pop on the same edge are both honoured. The FIFO count stays unchanged; full and empty are derived from the count.
- **start:**
  - Clears the pack count, the FIFO, any pending flush and words_done.
  - Loads the word address from {start_addr[23:2], 2'b00}.
  - An in-flight request is not retracted: the FSM stays in WAIT until it is acked, and that ack is not counted.
  - A byte presented on the start edge is dropped; byte_ready is forced to 0 in that cycle.
- **done:** combinational from state; it goes low on the same edge that the first byte is accepted.

Optional Feature:
- Macro: CRAM_LOAD_BYTESWAP_EN.
- Defined: lanes fill in order [7:0], [15:8], [23:16], [31:24] (little-endian packing). PAD fill follows the same lane order.
- Undefined: big-endian packing exactly as described under Behaviour.

Test Plan:
- **Basic packing:** start_addr=0x000100, then bytes 11,22,33,44,55,66,77,88 with an ack responder delaying 3 cycles.
  - Expect wraddr=0x000100/din=0x11223344, then wraddr=0x000104/din=0x55667788.
  - Expect words_done=2 and done=1 at the end.
- **Partial flush:** bytes AA,BB then flush.
  - Expect din=0xAABBFFFF at the start address.
  - With CRAM_LOAD_BYTESWAP_EN defined, expect din=0xFFFFBBAA.
- **Backpressure:** ack never returned, 5*DEPTH+8 bytes offered.
  - Expect byte_ready to drop after DEPTH words are buffered plus one issued, and no byte lost.
  - Release acks; all words must be acked in address order.
- **Address wrap:** start_addr=0xFFFFFC, 8 bytes.
  - Expect wraddr=0xFFFFFC, then 0x000000.
- **Abort:** start mid-request with 2 words queued and 3 bytes packed.
  - we_req is held until acked; words_done=0 afterwards.
  - The next 4 bytes go to the new start_addr.
- **Reset:** reset_n asserted while in WAIT.
  - Expect outputs at reset values immediately (asynchronous), then done=1 once reset_n is released.

Source files
------------

// File: rtl/cram_load_packer.sv
// Packs a byte stream into 32-bit words, queues them with their addresses and issues them
// to the cellular-RAM controller over a toggle handshake. Define CRAM_LOAD_BYTESWAP_EN for little-endian lane order.
module cram_load_packer #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] PAD   = 8'hFF
) (
    input  logic        cram_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] start_addr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        flush,
    output logic [23:0] wraddr,
    output logic [31:0] din,
    output logic        we_req,
    input  logic        we_ack,
    output logic [15:0] words_done,
    output logic        done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Bit offset of a byte lane inside the packed word.
    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
`ifdef CRAM_LOAD_BYTESWAP_EN
        return {lane, 3'b000};
`else
        return {~lane, 3'b000};
`endif
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[lane_lsb(lane) +: 8] = b;
        return r;
    endfunction

    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] filled);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(filled)) r[lane_lsb(2'(i)) +: 8] = PAD;
        end
        return r;
    endfunction

    logic [1:0]  pack_cnt_q, pack_cnt_d;
    logic [31:0] word_q, word_d;
    logic [23:0] addr_q, addr_d;
    logic        flush_pend_q, flush_pend_d;
    logic [31:0] fifo_data_q [DEPTH];
    logic [23:0] fifo_addr_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [0:0]  state_q, state_d;
    logic        we_req_q, we_req_d;
    logic [23:0] wraddr_q, wraddr_d;
    logic [31:0] din_q, din_d;
    logic [15:0] words_done_q, words_done_d;
    logic        abort_q, abort_d;

    logic        fifo_full, fifo_empty, accept, push, pop;
    logic [31:0] word_acc, push_data;
    logic [2:0]  filled;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^start_addr[1:0];
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign byte_ready = ~fifo_full & ~flush_pend_q & ~start;
    assign accept     = byte_valid & byte_ready;
    assign word_acc   = put_lane(word_q, pack_cnt_q, byte_data);
    assign filled     = {1'b0, pack_cnt_q} + {2'b00, accept};
    assign pop        = ~start & (state_q == S_IDLE) & (we_req_q == we_ack) & ~fifo_empty;

    always_comb begin
        push         = 1'b0;
        push_data    = word_acc;
        pack_cnt_d   = pack_cnt_q;
        word_d       = word_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
        if (start) begin
            pack_cnt_d   = 2'd0;
            flush_pend_d = 1'b0;
            addr_d       = {start_addr[23:2], 2'b00};
        end else if (accept && pack_cnt_q == 2'd3) begin
            // A flush on this edge refers to the next (empty) word, so it is dropped.
            push         = 1'b1;
            pack_cnt_d   = 2'd0;
            addr_d       = addr_q + 24'd4;
            flush_pend_d = 1'b0;
        end else if ((flush || flush_pend_q) && filled != 3'd0) begin
            if (!fifo_full) begin
                push         = 1'b1;
                push_data    = pad_word(word_acc, filled);
                pack_cnt_d   = 2'd0;
                addr_d       = addr_q + 24'd4;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end else begin
            flush_pend_d = 1'b0;
            if (accept) begin
                word_d     = word_acc;
                pack_cnt_d = pack_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        we_req_d     = we_req_q;
        wraddr_d     = wraddr_q;
        din_d        = din_q;
        words_done_d = words_done_q;
        abort_d      = abort_q;
        if (state_q == S_IDLE) begin
            if (pop) begin
                wraddr_d = fifo_addr_q[rd_ptr_q];
                din_d    = fifo_data_q[rd_ptr_q];
                we_req_d = ~we_req_q;
                state_d  = S_WAIT;
            end
        end else if (we_ack == we_req_q) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
            if (!abort_q) words_done_d = words_done_q + 16'd1;
        end
        // A request already issued keeps running, but its ack belongs to the old session.
        if (start) begin
            words_done_d = 16'd0;
            abort_d      = (state_d == S_WAIT);
        end
    end

    always_ff @(posedge cram_clk) begin
        if (push && !start) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_addr_q[wr_ptr_q] <= addr_q;
        end
    end

    always_ff @(posedge cram_clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_cnt_q   <= 2'd0;
            word_q       <= 32'd0;
            addr_q       <= 24'd0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            we_req_q     <= 1'b0;
            wraddr_q     <= 24'd0;
            din_q        <= 32'd0;
            words_done_q <= 16'd0;
            abort_q      <= 1'b0;
        end else begin
            pack_cnt_q   <= pack_cnt_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
            if (start) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            end
            state_q      <= state_d;
            we_req_q     <= we_req_d;
            wraddr_q     <= wraddr_d;
            din_q        <= din_d;
            words_done_q <= words_done_d;
            abort_q      <= abort_d;
        end
    end

    assign wraddr     = wraddr_q;
    assign din        = din_q;
    assign we_req     = we_req_q;
    assign words_done = words_done_q;
    assign done       = (pack_cnt_q == 2'd0) & fifo_empty & (we_req_q == we_ack) & ~flush_pend_q;

endmodule
